// File: rtl/scan_sequencer.sv
// Purpose : steps a 4-bit channel index W (with enable En) through channels 0..LAST_CH,
//           holding each channel for DWELL cycles, to drive a 4-to-16 one-hot decoder.
// Latency : Start accepted at edge k -> first channel on W/En at k+1; all outputs registered.
// Backpressure: none. Stop aborts a scan at the next edge; Start is ignored outside IDLE.
// Ports   : Clock, Reset (sync, active-high), Start, Stop, Mode (0 single-shot, 1 continuous),
//           W[3:0] channel index, En channel valid, Busy (in SCAN), Done (1-cycle end pulse).
// Option  : define SCAN_SKIP_MASK_EN to add Mask[15:0]; a set bit skips that channel.
module scan_sequencer #(
   parameter int DWELL   = 4,
   parameter int LAST_CH = 15
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic        Stop,
   input  logic        Mode,
`ifdef SCAN_SKIP_MASK_EN
   input  logic [15:0] Mask,
`endif
   output logic [3:0]  W,
   output logic        En,
   output logic        Busy,
   output logic        Done
);

   // Counter is wide enough for DWELL-1; with DWELL=1 it is a single bit stuck at 0.
   localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          mode_q;
   logic [3:0]    w_nxt;
   logic          en_nxt, busy_nxt, done_nxt;

   logic [15:0]   sel_mask;   // skip mask in force for this cycle
   logic [15:0]   avail;      // channels that may be visited
   logic [3:0]    first_ch, next_ch;
   logic          first_ok, next_ok;
   logic          accept, dwell_end;

`ifdef SCAN_SKIP_MASK_EN
   logic [15:0]   mask_q;
   // In IDLE the first channel must come from the live Mask, since it is
   // latched on the same edge that presents that first channel.
   assign sel_mask = (state == S_IDLE) ? Mask : mask_q;
`else
   assign sel_mask = '0;
`endif

   assign accept    = Start && !Stop;
   assign dwell_end = (cnt == CNT_LAST);

   // Lowest visitable channel, and lowest visitable channel above W.
   always_comb begin
      avail    = '0;
      first_ch = '0;
      first_ok = 1'b0;
      next_ch  = '0;
      next_ok  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         avail[i] = !sel_mask[i] && (i <= LAST_CH);
      end
      for (int i = 15; i >= 0; i--) begin
         if (avail[i]) begin
            first_ch = 4'(i);
            first_ok = 1'b1;
         end
         if (avail[i] && (i > int'(W))) begin
            next_ch = 4'(i);
            next_ok = 1'b1;
         end
      end
   end

   // State register plus registered outputs.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state  <= S_IDLE;
         cnt    <= '0;
         W      <= '0;
         En     <= 1'b0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
         mode_q <= 1'b0;
`ifdef SCAN_SKIP_MASK_EN
         mask_q <= '0;
`endif
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         W     <= w_nxt;
         En    <= en_nxt;
         Busy  <= busy_nxt;
         Done  <= done_nxt;
         if (state == S_IDLE && accept) begin
            mode_q <= Mode;
`ifdef SCAN_SKIP_MASK_EN
            mask_q <= Mask;
`endif
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = first_ok ? S_SCAN : S_DONE;
         S_SCAN: begin
            if (Stop)                                  state_nxt = S_IDLE;
            else if (dwell_end && !next_ok && !mode_q) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs and dwell counter.
   always_comb begin
      w_nxt    = W;
      cnt_nxt  = '0;
      en_nxt   = 1'b0;
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            w_nxt = '0;
            if (accept) begin
               if (first_ok) begin
                  w_nxt    = first_ch;
                  en_nxt   = 1'b1;
                  busy_nxt = 1'b1;
               end else begin
                  done_nxt = 1'b1;   // nothing to scan: straight to DONE
               end
            end
         end
         S_SCAN: begin
            if (Stop) begin
               w_nxt = '0;
            end else if (!dwell_end) begin
               cnt_nxt  = cnt + CW'(1);
               en_nxt   = 1'b1;
               busy_nxt = 1'b1;
            end else if (next_ok) begin
               w_nxt    = next_ch;
               en_nxt   = 1'b1;
               busy_nxt = 1'b1;
            end else if (mode_q) begin
               w_nxt    = first_ch;   // wrap with no gap cycle
               en_nxt   = 1'b1;
               busy_nxt = 1'b1;
            end else begin
               done_nxt = 1'b1;      // W holds on the last channel
            end
         end
         default: w_nxt = '0;        // DONE lasts one cycle
      endcase
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// Purpose : scoreboard bench for scan_sequencer; three instances with different DWELL/LAST_CH.
// Latency : stimulus pushes the outputs expected after the coming edge; monitor pops at negedge.
// Backpressure: none; every checked cycle carries exactly one expected entry per instance.
module tb_scan_sequencer;

`ifdef SCAN_SKIP_MASK_EN
   localparam int C_LAST = 15;
`else
   localparam int C_LAST = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst   [3];
   logic       start [3];
   logic       stop  [3];
   logic       mode  [3];
   logic [3:0] w_o   [3];
   logic       en_o  [3];
   logic       busy_o[3];
   logic       done_o[3];
`ifdef SCAN_SKIP_MASK_EN
   logic [15:0] mask [3];
`endif

   typedef struct packed {
      logic [7:0] tag;
      logic [3:0] w;
      logic       en;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];
   int   checks = 0;
   int   errors = 0;

   scan_sequencer #(.DWELL(4), .LAST_CH(15)) u_dut0 (
      .Clock(clk), .Reset(rst[0]), .Start(start[0]), .Stop(stop[0]), .Mode(mode[0]),
`ifdef SCAN_SKIP_MASK_EN
      .Mask(mask[0]),
`endif
      .W(w_o[0]), .En(en_o[0]), .Busy(busy_o[0]), .Done(done_o[0]));

   scan_sequencer #(.DWELL(1), .LAST_CH(15)) u_dut1 (
      .Clock(clk), .Reset(rst[1]), .Start(start[1]), .Stop(stop[1]), .Mode(mode[1]),
`ifdef SCAN_SKIP_MASK_EN
      .Mask(mask[1]),
`endif
      .W(w_o[1]), .En(en_o[1]), .Busy(busy_o[1]), .Done(done_o[1]));

   scan_sequencer #(.DWELL(2), .LAST_CH(C_LAST)) u_dut2 (
      .Clock(clk), .Reset(rst[2]), .Start(start[2]), .Stop(stop[2]), .Mode(mode[2]),
`ifdef SCAN_SKIP_MASK_EN
      .Mask(mask[2]),
`endif
      .W(w_o[2]), .En(en_o[2]), .Busy(busy_o[2]), .Done(done_o[2]));

   task automatic check(input int d, input exp_t e);
      logic [6:0] act;
      logic [6:0] req;
      act = {w_o[d], en_o[d], busy_o[d], done_o[d]};
      req = {e.w, e.en, e.busy, e.done};
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL dut%0d test%0d W/En/Busy/Done actual %h/%b/%b/%b required %h/%b/%b/%b",
                  d, e.tag, act[6:3], act[2], act[1], act[0], req[6:3], req[2], req[1], req[0]);
      end
   endtask

   // Monitor: outputs are stable at negedge; each entry was pushed before the preceding edge.
   always @(negedge clk) begin
      if (q0.size() > 0) check(0, q0.pop_front());
      if (q1.size() > 0) check(1, q1.pop_front());
      if (q2.size() > 0) check(2, q2.pop_front());
   end

   // One cycle of stimulus for instance d, plus the outputs expected after the next edge.
   task automatic cyc(input int d, input logic r, input logic st, input logic sp, input logic md,
                      input logic [7:0] tag, input logic [3:0] w, input logic en,
                      input logic busy, input logic done);
      exp_t e;
      @(negedge clk);
      #1;
      rst[d]   = r;
      start[d] = st;
      stop[d]  = sp;
      mode[d]  = md;
      e.tag = tag; e.w = w; e.en = en; e.busy = busy; e.done = done;
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic idle(input int d, input int n, input logic [7:0] tag);
      for (int i = 0; i < n; i++) cyc(d, 0, 0, 0, 0, tag, 4'd0, 0, 0, 0);
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; start[d] = 1'b0; stop[d] = 1'b0; mode[d] = 1'b0;
`ifdef SCAN_SKIP_MASK_EN
         mask[d] = 16'h0000;
`endif
      end

      // Reset state of every instance.
      for (int d = 0; d < 3; d++) begin
         cyc(d, 1, 0, 0, 0, 8'd0, 4'd0, 0, 0, 0);
         cyc(d, 0, 0, 0, 0, 8'd0, 4'd0, 0, 0, 0);
      end

      // 1: single-shot, DWELL=4: each channel 4 cycles, Done once, then IDLE with W=0.
      idle(0, 7, 8'd1);
      cyc(0, 0, 1, 0, 0, 8'd1, 4'd0, 1, 1, 0);
      for (int j = 1; j < 64; j++) cyc(0, 0, 0, 0, 0, 8'd1, 4'(j / 4), 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 8'd1, 4'd15, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 8'd1, 4'd0, 0, 0, 0);

      // 5: Start together with Stop in IDLE is refused.
      cyc(0, 0, 1, 1, 0, 8'd5, 4'd0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 8'd5, 4'd0, 0, 0, 0);

      // 3: Stop at W=5/counter=2, then restart from W=0.
      cyc(0, 0, 1, 0, 1, 8'd3, 4'd0, 1, 1, 0);
      for (int j = 1; j <= 22; j++) cyc(0, 0, 0, 0, 1, 8'd3, 4'(j / 4), 1, 1, 0);
      cyc(0, 0, 0, 1, 1, 8'd3, 4'd0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 8'd3, 4'd0, 1, 1, 0);
      for (int j = 1; j <= 5; j++) cyc(0, 0, 0, 0, 0, 8'd3, 4'(j / 4), 1, 1, 0);
      cyc(0, 0, 0, 1, 0, 8'd3, 4'd0, 0, 0, 0);

      // 4: Start during SCAN ignored; Reset at W=7 with Start held high.
      cyc(0, 0, 1, 0, 0, 8'd4, 4'd0, 1, 1, 0);
      for (int j = 1; j <= 29; j++)
         cyc(0, 0, (j == 13 || j == 14), 0, 0, 8'd4, 4'(j / 4), 1, 1, 0);
      cyc(0, 1, 1, 0, 0, 8'd4, 4'd0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0, 8'd4, 4'd0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 8'd4, 4'd0, 0, 0, 0);

      // 2: DWELL=1 continuous wraps 15 -> 0 with En held, no Done.
      cyc(1, 0, 1, 0, 1, 8'd2, 4'd0, 1, 1, 0);
      for (int j = 1; j <= 17; j++) cyc(1, 0, 0, 0, 0, 8'd2, 4'(j % 16), 1, 1, 0);
      cyc(1, 0, 0, 1, 0, 8'd2, 4'd0, 0, 0, 0);
      // DWELL=1 single-shot: one cycle per channel, then Done with W=15.
      cyc(1, 0, 1, 0, 0, 8'd7, 4'd0, 1, 1, 0);
      for (int j = 1; j <= 15; j++) cyc(1, 0, 0, 0, 0, 8'd7, 4'(j), 1, 1, 0);
      cyc(1, 0, 0, 0, 0, 8'd7, 4'd15, 0, 0, 1);
      cyc(1, 0, 0, 0, 0, 8'd7, 4'd0, 0, 0, 0);

`ifdef SCAN_SKIP_MASK_EN
      // 6: DWELL=2, Mask=FFF5 -> channels 1 and 3 only; Mask latched at Start.
      mask[2] = 16'hFFF5;
      cyc(2, 0, 1, 0, 0, 8'd6, 4'd1, 1, 1, 0);
      mask[2] = 16'h0000;
      cyc(2, 0, 0, 0, 0, 8'd6, 4'd1, 1, 1, 0);
      cyc(2, 0, 0, 0, 0, 8'd6, 4'd3, 1, 1, 0);
      cyc(2, 0, 0, 0, 0, 8'd6, 4'd3, 1, 1, 0);
      cyc(2, 0, 0, 0, 0, 8'd6, 4'd3, 0, 0, 1);
      cyc(2, 0, 0, 0, 0, 8'd6, 4'd0, 0, 0, 0);
      // Continuous with the same mask wraps 3 -> 1.
      mask[2] = 16'hFFF5;
      cyc(2, 0, 1, 0, 1, 8'd8, 4'd1, 1, 1, 0);
      cyc(2, 0, 0, 0, 0, 8'd8, 4'd1, 1, 1, 0);
      cyc(2, 0, 0, 0, 0, 8'd8, 4'd3, 1, 1, 0);
      cyc(2, 0, 0, 0, 0, 8'd8, 4'd3, 1, 1, 0);
      cyc(2, 0, 0, 0, 0, 8'd8, 4'd1, 1, 1, 0);
      cyc(2, 0, 0, 0, 0, 8'd8, 4'd1, 1, 1, 0);
      cyc(2, 0, 0, 1, 0, 8'd8, 4'd0, 0, 0, 0);
      // All masked: Done on the edge after Start, En never rises, either mode.
      mask[2] = 16'hFFFF;
      cyc(2, 0, 1, 0, 0, 8'd9, 4'd0, 0, 0, 1);
      cyc(2, 0, 0, 0, 0, 8'd9, 4'd0, 0, 0, 0);
      cyc(2, 0, 1, 0, 1, 8'd9, 4'd0, 0, 0, 1);
      cyc(2, 0, 0, 0, 0, 8'd9, 4'd0, 0, 0, 0);
`else
      // LAST_CH=0, DWELL=2 single-shot: one channel for 2 cycles, then Done.
      cyc(2, 0, 1, 0, 0, 8'd10, 4'd0, 1, 1, 0);
      cyc(2, 0, 0, 0, 0, 8'd10, 4'd0, 1, 1, 0);
      cyc(2, 0, 0, 0, 0, 8'd10, 4'd0, 0, 0, 1);
      cyc(2, 0, 0, 0, 0, 8'd10, 4'd0, 0, 0, 0);
      // LAST_CH=0 continuous: En stays high through repeated wraps.
      cyc(2, 0, 1, 0, 1, 8'd11, 4'd0, 1, 1, 0);
      for (int j = 1; j <= 5; j++) cyc(2, 0, 0, 0, 0, 8'd11, 4'd0, 1, 1, 0);
      cyc(2, 0, 0, 1, 0, 8'd11, 4'd0, 0, 0, 0);
`endif

      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (q0.size() + q1.size() + q2.size() != 0) begin
         errors++;
         $display("FAIL drain pending entries actual %0d required 0",
                  q0.size() + q1.size() + q2.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
